// File: rtl/fsic_io_serdes_pkg.sv
// Shared constants for the IO SERDES control block: register map, link states,
// CTRL reset image and interrupt bit positions.
package fsic_io_serdes_pkg;

  localparam int unsigned REG_CTRL       = 0;
  localparam int unsigned REG_STATUS     = 1;
  localparam int unsigned REG_TIMEOUT    = 2;
  localparam int unsigned REG_IRQ_STATUS = 3;
  localparam int unsigned REG_IRQ_EN     = 4;
  localparam int unsigned REG_TO_COUNT   = 5;

  localparam logic [31:0] CTRL_RST    = 32'h0000_FF04;
  localparam int unsigned TIMEOUT_RST = 1000;

  localparam int unsigned IRQ_UP      = 0;
  localparam int unsigned IRQ_TIMEOUT = 1;
  localparam int unsigned IRQ_LOST    = 2;
  localparam int unsigned IRQ_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX_ON = 3'd1,
    ST_WAIT  = 3'd2,
    ST_UP    = 3'd3,
    ST_FAIL  = 3'd4
  } link_state_e;

endpackage

// File: rtl/fsic_io_serdes_ctrl_if.sv
// AXI-Lite write/read channels (no B channel) between the core and the SERDES
// control block.
interface fsic_io_serdes_ctrl_if #(
  parameter int pADDR_WIDTH = 10,
  parameter int pDATA_WIDTH = 32
);
  logic                     axi_awvalid;
  logic [pADDR_WIDTH+1:2]   axi_awaddr;
  logic                     axi_awready;
  logic                     axi_wvalid;
  logic [pDATA_WIDTH-1:0]   axi_wdata;
  logic [pDATA_WIDTH/8-1:0] axi_wstrb;
  logic                     axi_wready;
  logic                     axi_arvalid;
  logic [pADDR_WIDTH+1:2]   axi_araddr;
  logic                     axi_arready;
  logic                     axi_rvalid;
  logic [pDATA_WIDTH-1:0]   axi_rdata;
  logic                     axi_rready;

  modport master (
    output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
           axi_arvalid, axi_araddr, axi_rready,
    input  axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
           axi_arvalid, axi_araddr, axi_rready,
    output axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
  );
endinterface

// File: rtl/fsic_sync2.sv
// Two-flop synchroniser for per-lane status bits crossing into axi_clk.
module fsic_sync2 #(
  parameter int pWIDTH = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [pWIDTH-1:0] d_i,
  output logic [pWIDTH-1:0] q_o
);
  logic [pWIDTH-1:0] meta_q;
  logic [pWIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/fsic_io_serdes_ctrl.sv
// AXI-Lite register bank plus link bring-up FSM for the multi-lane IO SERDES:
// sequences per-lane rx/tx enables, watches remote activity, times out, interrupts.
module fsic_io_serdes_ctrl
  import fsic_io_serdes_pkg::*;
#(
  parameter int pADDR_WIDTH = 10,
  parameter int pDATA_WIDTH = 32,
  parameter int pLANES      = 4,
  parameter int pTIMEOUT_W  = 16,
  parameter int pCLK_RATIO  = 4
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  fsic_io_serdes_ctrl_if.slave     axi,
  input  logic                     cc_is_enable,
  input  logic [pLANES-1:0]        lane_rx_active,
  output logic [pLANES-1:0]        lane_rxen,
  output logic [pLANES-1:0]        lane_txen,
  output logic                     link_up,
  output logic                     irq
);
  localparam int unsigned NB = pDATA_WIDTH / 8;

  logic                   rx_en_q, tx_en_q, auto_q, relink_q;
  logic [pLANES-1:0]      mask_q;
  logic [pTIMEOUT_W-1:0]  timeout_q, timer_q;
  logic [IRQ_W-1:0]       irq_status_q, irq_en_q, irq_set;
  logic [7:0]             to_cnt_q;
  logic                   rvalid_q, link_q;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d, wmask, wbits;
  logic [pLANES-1:0]      act_s, act_m, rxen_q, txen_q;
  link_state_e            state_q, state_d;
  logic wr_fire, rd_fire, wr_ctrl, wr_to, wr_istat, wr_ien, wr_tocnt;
  logic all_act, to_hit;

  fsic_sync2 #(.pWIDTH(pLANES)) u_sync (
    .clk_i   (axi_clk),
    .rst_n_i (axi_reset_n),
    .d_i     (lane_rx_active),
    .q_o     (act_s)
  );

  assign wr_fire         = axi.axi_awvalid & axi.axi_wvalid & cc_is_enable;
  assign axi.axi_awready = wr_fire;
  assign axi.axi_wready  = wr_fire;
  assign axi.axi_arready = ~rvalid_q;
  assign axi.axi_rvalid  = rvalid_q;
  assign axi.axi_rdata   = rdata_q;
  assign rd_fire         = axi.axi_arvalid & ~rvalid_q & cc_is_enable;

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < NB; i++) wmask[8*i +: 8] = {8{axi.axi_wstrb[i]}};
  end
  assign wbits = axi.axi_wdata & wmask;

  assign wr_ctrl  = wr_fire && (axi.axi_awaddr == pADDR_WIDTH'(REG_CTRL));
  assign wr_to    = wr_fire && (axi.axi_awaddr == pADDR_WIDTH'(REG_TIMEOUT));
  assign wr_istat = wr_fire && (axi.axi_awaddr == pADDR_WIDTH'(REG_IRQ_STATUS));
  assign wr_ien   = wr_fire && (axi.axi_awaddr == pADDR_WIDTH'(REG_IRQ_EN));
  assign wr_tocnt = wr_fire && (axi.axi_awaddr == pADDR_WIDTH'(REG_TO_COUNT));

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      rx_en_q   <= CTRL_RST[0];
      tx_en_q   <= CTRL_RST[1];
      auto_q    <= CTRL_RST[2];
      relink_q  <= 1'b0;
      mask_q    <= CTRL_RST[8 +: pLANES];
      timeout_q <= pTIMEOUT_W'(TIMEOUT_RST);
      irq_en_q  <= '0;
    end else begin
      relink_q <= wr_ctrl & wbits[3];
      if (wr_ctrl && axi.axi_wstrb[0]) begin
        rx_en_q <= axi.axi_wdata[0];
        tx_en_q <= axi.axi_wdata[1];
        auto_q  <= axi.axi_wdata[2];
      end
      if (wr_ctrl && axi.axi_wstrb[1]) mask_q <= axi.axi_wdata[8 +: pLANES];
      if (wr_to) timeout_q <= (timeout_q & ~wmask[pTIMEOUT_W-1:0]) | wbits[pTIMEOUT_W-1:0];
      if (wr_ien && axi.axi_wstrb[0]) irq_en_q <= axi.axi_wdata[IRQ_W-1:0];
    end
  end

  assign act_m   = act_s & mask_q;
  assign all_act = (act_m == mask_q);
  assign to_hit  = (timeout_q != '0) && (timer_q == timeout_q - pTIMEOUT_W'(1));

  // Per-state transitions first; relink then rx_en=0 override them, so rx_en=0 wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rx_en_q && (mask_q != '0)) state_d = ST_RX_ON;
      ST_RX_ON: if (tx_en_q || (auto_q && (|act_m))) state_d = ST_WAIT;
      ST_WAIT:  if (all_act) state_d = ST_UP;
                else if (to_hit) state_d = ST_FAIL;
      ST_UP:    if (!all_act) state_d = ST_WAIT;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && relink_q) state_d = ST_RX_ON;
    if (!rx_en_q) state_d = ST_IDLE;
  end

  always_comb begin
    irq_set              = '0;
    irq_set[IRQ_UP]      = (state_q != ST_UP) && (state_d == ST_UP);
    irq_set[IRQ_TIMEOUT] = (state_q == ST_WAIT) && (state_d == ST_FAIL);
    irq_set[IRQ_LOST]    = (state_q == ST_UP) && (state_d == ST_WAIT);
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      rxen_q  <= '0;
      txen_q  <= '0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= ((state_q == ST_WAIT) && (state_d == ST_WAIT)) ? timer_q + pTIMEOUT_W'(1) : '0;
      link_q  <= (state_d == ST_UP);
      case (state_d)
        ST_IDLE:  begin rxen_q <= '0;     txen_q <= '0;     end
        ST_RX_ON: begin rxen_q <= mask_q; txen_q <= '0;     end
        default:  begin rxen_q <= mask_q; txen_q <= mask_q; end
      endcase
    end
  end

  // A timeout event in the same cycle as a TO_COUNT write restarts the count at 1.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      irq_status_q <= '0;
      to_cnt_q     <= '0;
    end else begin
      irq_status_q <= (irq_status_q & ~(wr_istat ? wbits[IRQ_W-1:0] : '0)) | irq_set;
      if (irq_set[IRQ_TIMEOUT])
        to_cnt_q <= wr_tocnt ? 8'd1 : ((to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1);
      else if (wr_tocnt)
        to_cnt_q <= '0;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (axi.axi_araddr)
      pADDR_WIDTH'(REG_CTRL): begin
        rdata_d[0]            = rx_en_q;
        rdata_d[1]            = tx_en_q;
        rdata_d[2]            = auto_q;
        rdata_d[8 +: pLANES]  = mask_q;
      end
      pADDR_WIDTH'(REG_STATUS): begin
        rdata_d[2:0]          = state_q;
        rdata_d[4]            = link_q;
        rdata_d[8 +: pLANES]  = act_s;
        rdata_d[19:16]        = 4'(pCLK_RATIO);
        rdata_d[27:24]        = 4'(pLANES);
      end
      pADDR_WIDTH'(REG_TIMEOUT):    rdata_d[pTIMEOUT_W-1:0] = timeout_q;
      pADDR_WIDTH'(REG_IRQ_STATUS): rdata_d[IRQ_W-1:0]      = irq_status_q;
      pADDR_WIDTH'(REG_IRQ_EN):     rdata_d[IRQ_W-1:0]      = irq_en_q;
      pADDR_WIDTH'(REG_TO_COUNT):   rdata_d[7:0]            = to_cnt_q;
      default: ;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (rd_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
    end else if (rvalid_q && axi.axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign lane_rxen = rxen_q;
  assign lane_txen = txen_q;
  assign link_up   = link_q;
  assign irq       = |(irq_status_q & irq_en_q);

  logic unused_wbits;
  assign unused_wbits = ^{wbits, wmask};
endmodule

// File: tb/tb_fsic_io_serdes_ctrl.sv
// Directed bench for fsic_io_serdes_ctrl: register map, link bring-up, timeout,
// link loss, auto_txen, read back-pressure and cc_is_enable gating.
module tb_fsic_io_serdes_ctrl;
  logic       axi_clk = 1'b0;
  logic       axi_reset_n = 1'b0;
  logic       cc_is_enable = 1'b1;
  logic [3:0] lane_rx_active = 4'h0;
  logic [3:0] lane_rxen, lane_txen;
  logic       link_up, irq;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] rd_val;

  fsic_io_serdes_ctrl_if #(.pADDR_WIDTH(10), .pDATA_WIDTH(32)) axi_if ();

  fsic_io_serdes_ctrl #(
    .pADDR_WIDTH(10), .pDATA_WIDTH(32), .pLANES(4), .pTIMEOUT_W(16), .pCLK_RATIO(4)
  ) dut (
    .axi_clk        (axi_clk),
    .axi_reset_n    (axi_reset_n),
    .axi            (axi_if),
    .cc_is_enable   (cc_is_enable),
    .lane_rx_active (lane_rx_active),
    .lane_rxen      (lane_rxen),
    .lane_txen      (lane_txen),
    .link_up        (link_up),
    .irq            (irq)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge axi_clk);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge axi_clk);
    axi_if.axi_awaddr  = a;
    axi_if.axi_wdata   = d;
    axi_if.axi_wstrb   = s;
    axi_if.axi_awvalid = 1'b1;
    axi_if.axi_wvalid  = 1'b1;
    #1 check("awready", 32'(axi_if.axi_awready), 32'd1);
    @(negedge axi_clk);
    axi_if.axi_awvalid = 1'b0;
    axi_if.axi_wvalid  = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    int unsigned n = 0;
    @(negedge axi_clk);
    axi_if.axi_araddr  = a;
    axi_if.axi_arvalid = 1'b1;
    while (!axi_if.axi_arready && n < 8) begin
      @(negedge axi_clk);
      n++;
    end
    @(negedge axi_clk);
    axi_if.axi_arvalid = 1'b0;
    check("rvalid", 32'(axi_if.axi_rvalid), 32'd1);
    d = axi_if.axi_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_if.axi_awvalid = 1'b0;
    axi_if.axi_awaddr  = '0;
    axi_if.axi_wvalid  = 1'b0;
    axi_if.axi_wdata   = '0;
    axi_if.axi_wstrb   = '0;
    axi_if.axi_arvalid = 1'b0;
    axi_if.axi_araddr  = '0;
    axi_if.axi_rready  = 1'b1;

    cyc(3);
    check("rst_rxen",   32'(lane_rxen), 32'h0);
    check("rst_txen",   32'(lane_txen), 32'h0);
    check("rst_link",   32'(link_up), 32'h0);
    check("rst_irq",    32'(irq), 32'h0);
    check("rst_rvalid", 32'(axi_if.axi_rvalid), 32'h0);
    axi_reset_n = 1'b1;
    cyc(1);

    rd_chk("ctrl_rst",    10'h000, 32'h0000_0F04);
    rd_chk("status_rst",  10'h001, 32'h0404_0000);
    rd_chk("timeout_rst", 10'h002, 32'd1000);
    rd_chk("istat_rst",   10'h003, 32'h0);
    rd_chk("ien_rst",     10'h004, 32'h0);
    rd_chk("tocnt_rst",   10'h005, 32'h0);
    rd_chk("unmapped",    10'h3FF, 32'h0);

    // Bring-up to UP
    wr(10'h000, 32'h0000_0F03, 4'hF);
    cyc(1);
    check("up_rxen_rxon", 32'(lane_rxen), 32'hF);
    check("up_txen_rxon", 32'(lane_txen), 32'h0);
    cyc(1);
    check("up_rxen_wait", 32'(lane_rxen), 32'hF);
    check("up_txen_wait", 32'(lane_txen), 32'hF);
    cyc(10);
    lane_rx_active = 4'hF;
    cyc(2);
    check("up_link_early", 32'(link_up), 32'h0);
    cyc(1);
    check("up_link", 32'(link_up), 32'h1);
    rd_chk("up_status", 10'h001, 32'h0404_0F13);
    rd_chk("up_istat",  10'h003, 32'h1);
    check("up_irq_masked", 32'(irq), 32'h0);

    // Lose lane 1
    lane_rx_active = 4'b1101;
    cyc(2);
    check("lost_link_early", 32'(link_up), 32'h1);
    cyc(1);
    check("lost_link", 32'(link_up), 32'h0);
    rd_chk("lost_status", 10'h001, 32'h0404_0D02);
    rd_chk("lost_istat",  10'h003, 32'h5);
    wr(10'h003, 32'h7, 4'h0);
    rd_chk("w1c_nostrb", 10'h003, 32'h5);
    wr(10'h003, 32'h7, 4'h1);
    rd_chk("w1c_clear",  10'h003, 32'h0);
    wr(10'h000, 32'h0000_0F00, 4'hF);
    lane_rx_active = 4'h0;
    cyc(4);
    rd_chk("idle_status", 10'h001, 32'h0404_0000);

    // Timeout: FAIL exactly 5 cycles after entering WAIT
    wr(10'h004, 32'h2, 4'hF);
    wr(10'h002, 32'd5, 4'hF);
    wr(10'h000, 32'h0000_0F03, 4'hF);
    cyc(2);
    check("to_txen", 32'(lane_txen), 32'hF);
    cyc(4);
    check("to_irq_early", 32'(irq), 32'h0);
    cyc(1);
    check("to_irq", 32'(irq), 32'h1);
    rd_chk("to_count",  10'h005, 32'h1);
    rd_chk("to_status", 10'h001, 32'h0404_0004);
    rd_chk("to_istat",  10'h003, 32'h2);
    wr(10'h003, 32'h2, 4'hF);
    check("to_irq_clr", 32'(irq), 32'h0);
    wr(10'h005, 32'hAB, 4'hF);
    rd_chk("to_count_clr", 10'h005, 32'h0);

    // Relink from FAIL restarts at RX_ON; relink reads back 0
    wr(10'h000, 32'h0000_0F0B, 4'hF);
    cyc(1);
    check("relink_rxen", 32'(lane_rxen), 32'hF);
    check("relink_txen", 32'(lane_txen), 32'h0);
    rd_chk("relink_ctrl", 10'h000, 32'h0000_0F03);
    wr(10'h000, 32'h0000_0F00, 4'hF);

    // TIMEOUT field width and byte strobes
    wr(10'h002, 32'hFFFF_FFFF, 4'hF);
    rd_chk("to_width", 10'h002, 32'h0000_FFFF);
    wr(10'h002, 32'h0000_1234, 4'b0001);
    rd_chk("to_strb",  10'h002, 32'h0000_FF34);
    wr(10'h002, 32'h0, 4'hF);
    rd_chk("to_zero",  10'h002, 32'h0);

    // auto_txen with activity on lane 2 only, no timeout
    wr(10'h000, 32'h0000_0F05, 4'hF);
    cyc(1);
    check("auto_rxen", 32'(lane_rxen), 32'hF);
    check("auto_txen_off", 32'(lane_txen), 32'h0);
    lane_rx_active = 4'b0100;
    cyc(2);
    check("auto_txen_early", 32'(lane_txen), 32'h0);
    cyc(1);
    check("auto_txen_on", 32'(lane_txen), 32'hF);
    cyc(20);
    rd_chk("auto_status", 10'h001, 32'h0404_0402);

    // Read back-pressure
    @(negedge axi_clk);
    axi_if.axi_araddr  = 10'h000;
    axi_if.axi_arvalid = 1'b1;
    axi_if.axi_rready  = 1'b0;
    @(negedge axi_clk);
    axi_if.axi_arvalid = 1'b0;
    check("stall_rvalid0", 32'(axi_if.axi_rvalid), 32'h1);
    check("stall_rdata0",  axi_if.axi_rdata, 32'h0000_0F05);
    for (int i = 0; i < 4; i++) begin
      @(negedge axi_clk);
      check("stall_rvalid",  32'(axi_if.axi_rvalid), 32'h1);
      check("stall_rdata",   axi_if.axi_rdata, 32'h0000_0F05);
      check("stall_arready", 32'(axi_if.axi_arready), 32'h0);
    end
    axi_if.axi_rready = 1'b1;
    @(negedge axi_clk);
    check("stall_release_rvalid",  32'(axi_if.axi_rvalid), 32'h0);
    check("stall_release_arready", 32'(axi_if.axi_arready), 32'h1);

    // cc_is_enable = 0 blocks both channels
    @(negedge axi_clk);
    cc_is_enable       = 1'b0;
    axi_if.axi_araddr  = 10'h001;
    axi_if.axi_arvalid = 1'b1;
    axi_if.axi_awaddr  = 10'h000;
    axi_if.axi_wdata   = 32'h0;
    axi_if.axi_wstrb   = 4'hF;
    axi_if.axi_awvalid = 1'b1;
    axi_if.axi_wvalid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_clk);
      check("cc_rvalid",  32'(axi_if.axi_rvalid), 32'h0);
      check("cc_awready", 32'(axi_if.axi_awready), 32'h0);
      check("cc_wready",  32'(axi_if.axi_wready), 32'h0);
    end
    axi_if.axi_arvalid = 1'b0;
    axi_if.axi_awvalid = 1'b0;
    axi_if.axi_wvalid  = 1'b0;
    cc_is_enable       = 1'b1;
    rd_chk("cc_ctrl_kept", 10'h000, 32'h0000_0F05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
